// File: rtl/alu_board_sequencer.sv
// rtl/alu_board_sequencer.sv - key sync/debounce and operand-entry sequencer for the ALU
// Captures A, B and opcode from switches on debounced ENTER presses, registers ALU result.
module alu_board_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output logic [3:0]  aluop,
  input  logic [31:0] port_o,
  input  logic        flag_negative,
  input  logic        flag_overflow,
  input  logic        flag_zero,
  output logic [31:0] result,
  output logic [2:0]  res_flags,
  output logic        result_valid,
  output logic [3:0]  stage
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {S_GET_A, S_GET_B, S_GET_OP, S_EXEC, S_DONE} state_t;

  logic [1:0]    sync1, sync2, stable, stable_d, press;
  logic [CW-1:0] cnt [2];
  logic          enter_ev, clear_ev;
  logic [31:0]   operand;
  state_t        state, state_nx;

  logic unused_inputs;
  assign unused_inputs = ^{key_n[3:2], sw[17]};

  // Only ENTER (bit 0) and CLEAR (bit 1) are filtered; levels idle high.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      stable   <= 2'b11;
      stable_d <= 2'b11;
      press    <= 2'b00;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      sync1    <= key_n[1:0];
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == stable[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_MAX) begin
          stable[k] <= sync2[k];
          cnt[k]    <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  assign enter_ev = press[0];
  assign clear_ev = press[1];
  assign operand  = {{16{sw[16]}}, sw[15:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_GET_A;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_ev) begin
      state_nx = S_GET_A;
    end else begin
      case (state)
        S_GET_A:  if (enter_ev) state_nx = S_GET_B;
        S_GET_B:  if (enter_ev) state_nx = S_GET_OP;
        S_GET_OP: if (enter_ev) state_nx = S_EXEC;
        S_EXEC:   state_nx = S_DONE;
        S_DONE:   if (enter_ev) state_nx = S_GET_A;
        default:  state_nx = S_GET_A;
      endcase
    end
  end

  // CLEAR outranks any capture, including the EXEC result load.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      port_a    <= '0;
      port_b    <= '0;
      aluop     <= '0;
      result    <= '0;
      res_flags <= '0;
    end else if (clear_ev) begin
      port_a    <= '0;
      port_b    <= '0;
      aluop     <= '0;
      result    <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        S_GET_A:  if (enter_ev) port_a <= operand;
        S_GET_B:  if (enter_ev) port_b <= operand;
        S_GET_OP: if (enter_ev) aluop <= sw[3:0];
        S_EXEC: begin
          result    <= port_o;
          res_flags <= {flag_negative, flag_overflow, flag_zero};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stage        = 4'b0001;
    result_valid = 1'b0;
    case (state)
      S_GET_A:  stage = 4'b0001;
      S_GET_B:  stage = 4'b0010;
      S_GET_OP: stage = 4'b0100;
      S_EXEC:   stage = 4'b1000;
      S_DONE: begin
        stage        = 4'b1000;
        result_valid = 1'b1;
      end
      default:  stage = 4'b0001;
    endcase
  end

endmodule

// File: tb/tb_alu_board_sequencer.sv
// tb/tb_alu_board_sequencer.sv - directed bench for alu_board_sequencer with ALU stub
// Expected ALU results are queued at stimulus time and popped when result_valid rises.
module tb_alu_board_sequencer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic [17:0] sw = '0;
  logic [31:0] port_a, port_b, port_o, result;
  logic [3:0]  aluop, stage;
  logic        flag_negative, flag_overflow, flag_zero, result_valid;
  logic [2:0]  res_flags;

  int compared = 0;
  int mismatched = 0;
  logic [34:0] sb_q[$];
  logic rv_d = 1'b0;

  alu_board_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw(sw),
    .port_a(port_a), .port_b(port_b), .aluop(aluop), .port_o(port_o),
    .flag_negative(flag_negative), .flag_overflow(flag_overflow), .flag_zero(flag_zero),
    .result(result), .res_flags(res_flags), .result_valid(result_valid), .stage(stage)
  );

  always #5 CLK = ~CLK;

  // ALU stub: ADD 0010, SUB 0011, anything else yields 0.
  always_comb begin
    port_o        = '0;
    flag_overflow = 1'b0;
    case (aluop)
      4'b0010: begin
        port_o        = port_a + port_b;
        flag_overflow = (port_a[31] == port_b[31]) && (port_o[31] != port_a[31]);
      end
      4'b0011: begin
        port_o        = port_a - port_b;
        flag_overflow = (port_a[31] != port_b[31]) && (port_o[31] != port_a[31]);
      end
      default: port_o = '0;
    endcase
  end
  assign flag_negative = port_o[31];
  assign flag_zero     = (port_o == 32'd0);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (result_valid && !rv_d) begin
      if (sb_q.size() == 0) chk("sb_unexpected_result", 128'(sb_q.size()), 128'd1);
      else                  chk("sb_result", 128'({result, res_flags}), 128'(sb_q.pop_front()));
    end
    rv_d = result_valid;
  end

  task automatic hold_keys(input logic [3:0] mask, input int n);
    key_n = key_n & ~mask;
    repeat (n) @(negedge CLK);
    key_n = 4'hF;
    repeat (10) @(negedge CLK);
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 30 && !result_valid; k++) @(negedge CLK);
    chk(tag, 128'(result_valid), 128'd1);
  endtask

  // Key (or reset release) applied at the negedge just before edge E0.
  task automatic check_latency(input string tag);
    repeat (7) @(negedge CLK);
    chk({tag, "_early"}, 128'(stage), 128'(4'b0001));
    @(negedge CLK);
    chk({tag, "_event"}, 128'(stage), 128'(4'b0010));
  endtask

  localparam logic [107:0] RST_VEC = {32'd0, 32'd0, 4'd0, 32'd0, 3'd0, 1'b0, 4'b0001};

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 128'({port_a, port_b, aluop, result, res_flags, result_valid, stage}),
        128'(RST_VEC));
    nRST = 1'b1;
    repeat (20) @(negedge CLK);
    chk("no_spurious_press", 128'({stage, result_valid}), 128'({4'b0001, 1'b0}));

    sw = 18'h00005;
    hold_keys(4'b0001, 10);
    chk("add_port_a", 128'(port_a), 128'(32'h00000005));
    sw = 18'h1FFFF;
    hold_keys(4'b0001, 10);
    chk("add_port_b", 128'(port_b), 128'(32'hFFFFFFFF));
    sw = 18'h00002;
    sb_q.push_back({32'h00000004, 3'b000});
    hold_keys(4'b0001, 10);
    wait_valid("add_done");
    chk("add_aluop_stage", 128'({aluop, stage}), 128'({4'b0010, 4'b1000}));
    hold_keys(4'b0001, 10);
    chk("add_back_to_a", 128'(stage), 128'(4'b0001));

    sw = 18'h01234;
    hold_keys(4'b0001, 10);
    hold_keys(4'b0001, 10);
    sw = 18'h00003;
    sb_q.push_back({32'h00000000, 3'b001});
    hold_keys(4'b0001, 10);
    wait_valid("sub_done");
    hold_keys(4'b0001, 10);
    chk("sub_retained", 128'({stage, result, res_flags}), 128'({4'b0001, 32'd0, 3'b001}));

    sw = 18'h18000;
    key_n[0] = 1'b0; repeat (3) @(negedge CLK);
    key_n[0] = 1'b1; repeat (2) @(negedge CLK);
    key_n[0] = 1'b0; repeat (3) @(negedge CLK);
    key_n[0] = 1'b1; repeat (10) @(negedge CLK);
    chk("bounce_no_event", 128'({stage, port_a}), 128'({4'b0001, 32'h00001234}));
    key_n[0] = 1'b0;
    check_latency("bounce_latency");
    repeat (32) @(negedge CLK);
    chk("held_single_event", 128'(stage), 128'(4'b0010));
    key_n[0] = 1'b1;
    repeat (10) @(negedge CLK);
    chk("sign_fill", 128'(port_a), 128'(32'hFFFF8000));
    sw = 18'h00001;
    repeat (5) @(negedge CLK);
    chk("sw_change_ignored", 128'(port_a), 128'(32'hFFFF8000));

    sw = 18'h00007;
    hold_keys(4'b0001, 10);
    chk("clr_setup", 128'({stage, port_b}), 128'({4'b0100, 32'h00000007}));
    sw = 18'h00002;
    hold_keys(4'b0011, 10);
    chk("clear_priority", 128'({stage, port_a, port_b, aluop, result, res_flags}),
        128'({4'b0001, 32'd0, 32'd0, 4'd0, 32'd0, 3'd0}));

    sw = 18'h00005;
    hold_keys(4'b0001, 10);
    key_n[0] = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("reset_mid_run", 128'({port_a, port_b, aluop, result, res_flags, result_valid, stage}),
        128'(RST_VEC));
    @(negedge CLK);
    nRST = 1'b1;
    check_latency("reset_latency");
    key_n[0] = 1'b1;
    repeat (10) @(negedge CLK);
    chk("post_reset_capture", 128'(port_a), 128'(32'h00000005));

    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
